// File: rtl/ddr_sched.sv
// ddr_sched: shares the single DDR port between instruction fetch (pc),
// LSU store and LSU load. Issues one operation at a time with fixed
// priority (load > store > pc) plus per-requester starvation promotion,
// squashes fetch results on redirect and steers completion data back.
module ddr_sched #(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         redirect_valid,
    input  logic         pc_index_valid,
    input  logic [18:0]  pc_index,
    output logic         pc_index_ready,
    output logic [511:0] pc_read_inst,
    output logic         pc_operation_done,
    input  logic         opstore_index_valid,
    input  logic [18:0]  opstore_index,
    output logic         opstore_index_ready,
    input  logic [63:0]  opstore_write_mask,
    input  logic [63:0]  opstore_write_data,
    output logic         opstore_operation_done,
    input  logic         opload_index_valid,
    input  logic [18:0]  opload_index,
    output logic         opload_index_ready,
    output logic [63:0]  opload_read_data,
    output logic         opload_operation_done,
    output logic         ddr_chip_enable,
    output logic [18:0]  ddr_index,
    output logic         ddr_write_enable,
    output logic         ddr_burst_mode,
    output logic [63:0]  ddr_opstore_write_mask,
    output logic [63:0]  ddr_opstore_write_data,
    input  logic [63:0]  ddr_opload_read_data,
    input  logic [511:0] ddr_pc_read_inst,
    input  logic         ddr_operation_done,
    input  logic         ddr_ready
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_PC, OWN_ST, OWN_LD} owner_t;

    state_t      state, state_next;
    owner_t      owner, winner;
    logic [7:0]  wait_pc, wait_st, wait_ld;
    logic        kill;
    logic        can_grant, grant;
    logic        elig_pc, elig_st, elig_ld;
    logic        starve_pc, starve_st, starve_ld;
    logic [18:0] grant_index;

    // Wait counter step: clear when idle or granted, otherwise count up and stick at the limit.
    function automatic logic [7:0] next_wait(input logic valid, input logic granted,
                                             input logic [7:0] cnt);
        if (!valid || granted) return '0;
        if (cnt == LIMIT) return cnt;
        return cnt + 8'd1;
    endfunction

    // Arbitration: starved requesters outrank everyone, ties and the rest by load > store > pc.
    always_comb begin
        elig_pc   = pc_index_valid & ~redirect_valid;
        elig_st   = opstore_index_valid;
        elig_ld   = opload_index_valid;
        starve_pc = elig_pc && (wait_pc == LIMIT);
        starve_st = elig_st && (wait_st == LIMIT);
        starve_ld = elig_ld && (wait_ld == LIMIT);
        winner    = OWN_NONE;
        if (starve_ld)      winner = OWN_LD;
        else if (starve_st) winner = OWN_ST;
        else if (starve_pc) winner = OWN_PC;
        else if (elig_ld)   winner = OWN_LD;
        else if (elig_st)   winner = OWN_ST;
        else if (elig_pc)   winner = OWN_PC;
        can_grant   = (state == IDLE) && ddr_ready;
        grant       = can_grant && (winner != OWN_NONE);
        grant_index = '0;
        case (winner)
            OWN_LD:  grant_index = opload_index;
            OWN_ST:  grant_index = opstore_index;
            OWN_PC:  grant_index = pc_index;
            default: grant_index = '0;
        endcase
    end

    // Handshake readies and completion pulses; readies are forced low while reset is held.
    always_comb begin
        opload_index_ready     = reset_n && grant && (winner == OWN_LD);
        opstore_index_ready    = reset_n && grant && (winner == OWN_ST);
        pc_index_ready         = reset_n && grant && (winner == OWN_PC);
        opload_operation_done  = (state == RESP) && (owner == OWN_LD);
        opstore_operation_done = (state == RESP) && (owner == OWN_ST);
        pc_operation_done      = (state == RESP) && (owner == OWN_PC) && !kill;
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state logic: grant -> wait for DDR -> one response cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant) state_next = BUSY;
            BUSY:    if (ddr_operation_done) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Per-requester starvation counters.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wait_pc <= '0;
            wait_st <= '0;
            wait_ld <= '0;
        end else begin
            wait_pc <= next_wait(pc_index_valid,      grant && (winner == OWN_PC), wait_pc);
            wait_st <= next_wait(opstore_index_valid, grant && (winner == OWN_ST), wait_st);
            wait_ld <= next_wait(opload_index_valid,  grant && (winner == OWN_LD), wait_ld);
        end
    end

    // Issue registers: latched at grant, held through BUSY/RESP, cleared on return to IDLE.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            owner                  <= OWN_NONE;
            ddr_chip_enable        <= 1'b0;
            ddr_index              <= '0;
            ddr_write_enable       <= 1'b0;
            ddr_burst_mode         <= 1'b0;
            ddr_opstore_write_mask <= '0;
            ddr_opstore_write_data <= '0;
        end else begin
            ddr_chip_enable <= grant;
            if (grant) begin
                owner                  <= winner;
                ddr_index              <= grant_index;
                ddr_write_enable       <= (winner == OWN_ST);
                ddr_burst_mode         <= (winner == OWN_PC);
                ddr_opstore_write_mask <= (winner == OWN_ST) ? opstore_write_mask : '0;
                ddr_opstore_write_data <= (winner == OWN_ST) ? opstore_write_data : '0;
            end else if (state == RESP) begin
                owner                  <= OWN_NONE;
                ddr_index              <= '0;
                ddr_write_enable       <= 1'b0;
                ddr_burst_mode         <= 1'b0;
                ddr_opstore_write_mask <= '0;
                ddr_opstore_write_data <= '0;
            end
        end
    end

    // Fetch kill flag and completion data capture.
    // A redirect in the completion cycle itself suppresses the capture directly,
    // since the kill flag only becomes visible one cycle later.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            kill             <= 1'b0;
            pc_read_inst     <= '0;
            opload_read_data <= '0;
        end else begin
            if (state == RESP)
                kill <= 1'b0;
            else if (redirect_valid && (((state == BUSY) && (owner == OWN_PC)) ||
                                        (grant && (winner == OWN_PC))))
                kill <= 1'b1;
            if ((state == BUSY) && ddr_operation_done) begin
                if (owner == OWN_LD)
                    opload_read_data <= ddr_opload_read_data;
                if ((owner == OWN_PC) && !kill && !redirect_valid)
                    pc_read_inst <= ddr_pc_read_inst;
            end
        end
    end

endmodule
